morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side stage for the Morse letter path: consumes the serial symbol stream that the Morse encoder drives onto its LED output, one symbol per symbol-rate strobe. Reassembles each 14-symbol letter frame and matches it against the eight-entry letter table (S–Z). Reports the recovered 3-bit letter code with a one-cycle valid pulse, or an error pulse on no match. Sits directly downstream of the encoder's shift register and shares its symbol-rate enable from the rate divider.

## Interface
- CODE_W, 14, symbols per letter frame; the table below is defined for 14 only.
- clk  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- sym_en  input  1  symbol strobe: one-clk-wide pulse per symbol period, from the rate divider.
- serial_in  input  1  symbol stream: 1 = tone (LED on), 0 = gap; sampled only when sym_en=1.
- letter  output  3  last successfully decoded letter code; held between decodes.
- valid  output  1  one-clk pulse: letter has just been updated.
- error  output  1  one-clk pulse: captured frame matched no table entry.
- busy  output  1  high while a frame is being captured or matched (state != IDLE).
- frame  output  14  last captured frame; first-received symbol in bit 13.

## Operation
- Letter table, MSB = first symbol: 000=10101000000000 (S), 001=11100000000000 (T), 010=10101110000000 (U), 011=10101011100000 (V), 100=10111011100000 (W), 101=11101010111000 (X), 110=11101011101110 (Y), 111=11101110101000 (Z).
- All state and outputs are registered. A 14-bit shift register captures the frame; a 4-bit counter counts symbols.
- States: IDLE, CAPTURE, MATCH.
- IDLE: a sym_en with serial_in=0 is ignored (inter-letter gap). A sym_en with serial_in=1 loads shreg <= 14'b1 into bit 0, sets count=1, and moves to CAPTURE. Every valid code starts with 1, so a frame always begins on the first tone.
- CAPTURE: on each sym_en, shreg <= {shreg[12:0], serial_in} and count <= count+1. The sym_en that brings count to 14 moves to MATCH. Clock cycles without sym_en hold all state.
- MATCH: lasts exactly one cycle. frame <= shreg. On an exact 14-bit match with table entry k: letter <= k and valid <= 1. On no match: error <= 1 and letter is unchanged. Then go to IDLE with count=0.
- sym_en in the MATCH cycle is ignored; the symbol it carries is lost.
- valid and error are never both high and are each high for exactly one clk.
- The counter never exceeds 14 and has no wrap-around path.

## Timing
- Reset: state=IDLE, shreg=0, count=0, letter=000, frame=0, valid=0, error=0, busy=0. All take effect on the first rising edge with reset=1.
- Reset asserted mid-CAPTURE or in MATCH discards the partial frame. No valid or error pulse is produced on or after that edge.
- Reset has priority over sym_en in the same cycle.
- Edge E0 samples the 14th symbol and enters MATCH. Edge E1 registers letter, frame, and valid/error, and returns to IDLE. valid/error are high from E1 to E2.
- Decode latency: 1 clk after the 14th-symbol edge.
- busy rises on the edge that samples the first tone and falls on E1.
- A new frame may start on the next sym_en after E1, including the very next symbol period.

## Test plan
- Decode S: after reset, drive 10101000000000 on 14 consecutive sym_en pulses (strobe every 4 clks), with idle zeros before and after. Required: letter=000, valid high for exactly 1 clk, 1 clk after the 14th strobe edge; frame=0x2A00; error stays 0.
- Full table: send all eight codes back to back, each preceded by three 0 symbols. Required: valid pulses with letter = 000 through 111 in order; zero error pulses.
- Bad frame: send 11111111111111. Required: error pulse 1 clk after the 14th strobe edge; valid=0; letter keeps its previous value (e.g. 101 after a prior X); frame=0x3FFF.
- Leading gaps and strobe gating: hold serial_in=1 for 20 clks with sym_en=0, then send T preceded by five 0 symbols. Required: busy stays 0 until the first strobe with serial_in=1; decodes letter=001.
- Reset mid-frame: send the first 7 symbols of Y, assert reset for 1 clk, then send a complete W. Required: no pulse for the aborted frame; all outputs are 0 after the reset edge; then valid with letter=100.
- Back-to-back frames: send Z immediately followed by U starting on the first strobe after the decode edge, with strobes every 3 clks. Required: letter=111 then letter=010, two valid pulses, no error.

Source files
------------

// File: rtl/morse_decoder_if.sv
// morse_decoder_if
//   Bundles the symbol-stream inputs and the decode results of the Morse
//   letter decoder.
//
//   Handshake: there is no backpressure. sym_en is a one-clk strobe and
//   serial_in is sampled only on clocks where sym_en=1. valid and error are
//   one-clk pulses, mutually exclusive, that tell the consumer letter/frame
//   have just been refreshed. The consumer must take them in that clock.
//
//   Signals:
//     sym_en     symbol strobe (one clk per symbol period)
//     serial_in  symbol value, 1 = tone, 0 = gap
//     letter     last decoded letter code, held between decodes
//     valid      one-clk pulse: letter updated
//     error      one-clk pulse: captured frame matched nothing
//     busy       high while a frame is captured or matched
//     frame      last captured frame, first symbol in the MSB
//
//   Modports: master = symbol source / result consumer, slave = decoder.
interface morse_decoder_if #(
    parameter int CODE_W = 14
);
    logic              sym_en;
    logic              serial_in;
    logic [2:0]        letter;
    logic              valid;
    logic              error;
    logic              busy;
    logic [CODE_W-1:0] frame;

    modport master (
        output sym_en, serial_in,
        input  letter, valid, error, busy, frame
    );

    modport slave (
        input  sym_en, serial_in,
        output letter, valid, error, busy, frame
    );
endinterface

// File: rtl/morse_decoder.sv
// morse_decoder
//   Reassembles 14-symbol Morse letter frames from the encoder's serial LED
//   stream and matches them against the eight-letter table S..Z.
//
//   Ports:
//     clk      system clock
//     reset    synchronous active-high reset
//     bus      morse_decoder_if.slave (sym_en, serial_in in; letter, valid,
//              error, busy, frame out)
//     state_o  current FSM state (0 = IDLE, 1 = CAPTURE, 2 = MATCH)
//
//   A frame starts on the first tone seen while idle, so leading gap
//   symbols between letters are skipped. The symbol that brings the count
//   to 14 moves the FSM to MATCH; the following clock registers the result
//   and returns to IDLE. Any strobe arriving during MATCH is dropped.
module morse_decoder (
    input  logic            clk,
    input  logic            reset,
    morse_decoder_if.slave  bus,
    output logic [1:0]      state_o
);
    localparam int CODE_W = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        MATCH   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CODE_W-1:0] shreg_q;
    logic [3:0]        count_q;
    logic [2:0]        letter_q;
    logic [CODE_W-1:0] frame_q;
    logic              valid_q;
    logic              error_q;
    logic              busy_q;

    logic [CODE_W-1:0] shreg_d;
    logic [3:0]        count_d;
    logic              hit;
    logic [2:0]        hit_idx;

    // Letter table, first symbol in the MSB.
    function automatic logic [CODE_W-1:0] table_code(input logic [2:0] k);
        case (k)
            3'd0:    table_code = 14'b10101000000000; // S
            3'd1:    table_code = 14'b11100000000000; // T
            3'd2:    table_code = 14'b10101110000000; // U
            3'd3:    table_code = 14'b10101011100000; // V
            3'd4:    table_code = 14'b10111011100000; // W
            3'd5:    table_code = 14'b11101010111000; // X
            3'd6:    table_code = 14'b11101011101110; // Y
            default: table_code = 14'b11101110101000; // Z
        endcase
    endfunction

    assign shreg_d = {shreg_q[CODE_W-2:0], bus.serial_in};
    assign count_d = count_q + 4'd1;

    // Table entries are all distinct, so at most one can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (shreg_q == table_code(k[2:0])) begin
                hit     = 1'b1;
                hit_idx = k[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            letter_q <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Gap symbols between letters are ignored; the first
                    // tone is always the first symbol of a frame.
                    if (bus.sym_en && bus.serial_in) begin
                        shreg_q <= 14'd1;
                        count_q <= 4'd1;
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bus.sym_en) begin
                        shreg_q <= shreg_d;
                        count_q <= count_d;
                        if (count_q == 4'd13) begin
                            state_q <= MATCH;
                        end
                    end
                end
                MATCH: begin
                    frame_q <= shreg_q;
                    if (hit) begin
                        letter_q <= hit_idx;
                        valid_q  <= 1'b1;
                    end else begin
                        error_q  <= 1'b1;
                    end
                    count_q <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.letter = letter_q;
    assign bus.frame  = frame_q;
    assign bus.valid  = valid_q;
    assign bus.error  = error_q;
    assign bus.busy   = busy_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: a table of letter frames with
// expected results, plus hand-written sequences for reset, strobe gating and
// back-to-back frames. A monitor matches every valid pulse against an
// expected-letter queue.
module tb_morse_decoder;
    logic       clk;
    logic       reset;
    logic [1:0] state_o;

    morse_decoder_if #(.CODE_W(14)) bus ();

    morse_decoder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int err_exp  = 0;
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("sb_letter", {29'd0, bus.letter}, {29'd0, exp_q.pop_front()});
            end
        end
        if (bus.error === 1'b1) err_seen++;
        if (bus.valid === 1'b1 && bus.error === 1'b1) chk("valid_and_error", 32'd1, 32'd0);
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; leaves idle_clks quiet clocks, then a
    // one-clk strobe carrying b. Returns 1 ns after the edge that samples it.
    task automatic send_sym(input logic b, input int idle_clks);
        repeat (idle_clks) begin
            @(posedge clk);
            #1;
        end
        bus.sym_en    = 1'b1;
        bus.serial_in = b;
        @(posedge clk);
        #1;
        bus.sym_en    = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    task automatic send_frame(input logic [13:0] code, input int idle_clks);
        for (int i = 13; i >= 0; i--) send_sym(code[i], idle_clks);
    endtask

    // Called 1 ns after the 14th-symbol edge (E0). Checks E1 results and,
    // if check_e2, that the pulse has dropped one clock later.
    task automatic check_decode(input string name, input logic exp_valid,
                                input logic [2:0] exp_letter, input logic [13:0] exp_frame,
                                input logic check_e2);
        if (exp_valid) exp_q.push_back(exp_letter);
        else err_exp++;
        chk({name, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
        chk({name, "_valid_e0"}, {31'd0, bus.valid}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, {31'd0, bus.valid}, {31'd0, exp_valid});
        chk({name, "_error"}, {31'd0, bus.error}, {31'd0, ~exp_valid});
        chk({name, "_letter"}, {29'd0, bus.letter}, {29'd0, exp_letter});
        chk({name, "_frame"}, {18'd0, bus.frame}, {18'd0, exp_frame});
        chk({name, "_busy_e1"}, {31'd0, bus.busy}, 32'd0);
        if (check_e2) begin
            @(posedge clk);
            #1;
            chk({name, "_valid_e2"}, {31'd0, bus.valid}, 32'd0);
            chk({name, "_error_e2"}, {31'd0, bus.error}, 32'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [13:0] code;
        logic        exp_valid;
        logic [2:0]  exp_letter;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic busy_seen;

        vecs[0] = '{"S",   14'b10101000000000, 1'b1, 3'd0};
        vecs[1] = '{"T",   14'b11100000000000, 1'b1, 3'd1};
        vecs[2] = '{"U",   14'b10101110000000, 1'b1, 3'd2};
        vecs[3] = '{"V",   14'b10101011100000, 1'b1, 3'd3};
        vecs[4] = '{"W",   14'b10111011100000, 1'b1, 3'd4};
        vecs[5] = '{"X",   14'b11101010111000, 1'b1, 3'd5};
        vecs[6] = '{"Y",   14'b11101011101110, 1'b1, 3'd6};
        vecs[7] = '{"Z",   14'b11101110101000, 1'b1, 3'd7};
        vecs[8] = '{"X2",  14'b11101010111000, 1'b1, 3'd5};
        vecs[9] = '{"BAD", 14'b11111111111111, 1'b0, 3'd5};

        reset         = 1'b1;
        bus.sym_en    = 1'b0;
        bus.serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_letter", {29'd0, bus.letter}, 32'd0);
        chk("rst_frame", {18'd0, bus.frame}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);

        // Decode S with idle zeros before and after, strobe every 4 clks
        for (int i = 0; i < 3; i++) send_sym(1'b0, 3);
        send_frame(14'b10101000000000, 3);
        check_decode("S_first", 1'b1, 3'd0, 14'h2A00, 1'b1);
        for (int i = 0; i < 3; i++) send_sym(1'b0, 3);
        chk("S_idle_after_busy", {31'd0, bus.busy}, 32'd0);

        // Full table, then X and a bad frame; three gap symbols before each
        for (int v = 0; v < 10; v++) begin
            for (int g = 0; g < 3; g++) send_sym(1'b0, 3);
            send_frame(vecs[v].code, 3);
            check_decode(vecs[v].name, vecs[v].exp_valid, vecs[v].exp_letter,
                         vecs[v].code, 1'b1);
        end

        // Leading gaps and strobe gating
        bus.serial_in = 1'b1;
        busy_seen     = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        chk("gate_no_strobe_busy", {31'd0, busy_seen}, 32'd0);
        bus.serial_in = 1'b0;
        for (int i = 0; i < 5; i++) send_sym(1'b0, 3);
        chk("gate_zeros_busy", {31'd0, bus.busy}, 32'd0);
        send_sym(1'b1, 3);
        chk("gate_first_tone_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 12; i >= 0; i--) send_sym(vecs[1].code[i], 3);
        check_decode("T_gated", 1'b1, 3'd1, 14'h3800, 1'b1);

        // Reset mid-frame: first 7 symbols of Y, then reset
        for (int i = 13; i >= 7; i--) send_sym(vecs[6].code[i], 3);
        chk("abort_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_letter", {29'd0, bus.letter}, 32'd0);
        chk("abort_frame", {18'd0, bus.frame}, 32'd0);
        chk("abort_valid", {31'd0, bus.valid}, 32'd0);
        chk("abort_error", {31'd0, bus.error}, 32'd0);
        chk("abort_busy_low", {31'd0, bus.busy}, 32'd0);
        chk("abort_state", {30'd0, state_o}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        send_frame(vecs[4].code, 3);
        check_decode("W_after_abort", 1'b1, 3'd4, 14'h2EE0, 1'b1);

        // Back-to-back: Z then U starting on the strobe right after E1
        send_frame(vecs[7].code, 2);
        check_decode("Z_b2b", 1'b1, 3'd7, 14'h3BA8, 1'b0);
        send_sym(1'b1, 0);
        chk("b2b_valid_e2", {31'd0, bus.valid}, 32'd0);
        chk("b2b_busy_restart", {31'd0, bus.busy}, 32'd1);
        for (int i = 12; i >= 0; i--) send_sym(vecs[2].code[i], 2);
        check_decode("U_b2b", 1'b1, 3'd2, 14'h2B80, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_queue_empty", exp_q.size(), 32'd0);
        chk("error_pulse_count", err_seen, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
